// File: rtl/ex3_serial_rx_if.sv
// Parallel Excess-3 digit handshake between the serial receiver (master)
// and the downstream converter (slave).
interface ex3_serial_rx_if;
    logic [3:0] E;
    logic       e_valid;
    logic       e_ready;
    logic       e_last;
    logic       e_err;

    modport master (output E, output e_valid, output e_last, output e_err, input e_ready);
    modport slave  (input E, input e_valid, input e_last, input e_err, output e_ready);
endinterface

// File: rtl/ex3_serial_rx.sv
// Bit-serial Excess-3 frame receiver: MSB-first nibbles in, one-deep handshaked digit register out.
// Optional illegal-code tagging is built when EX3_CODE_CHECK_EN is defined.
module ex3_serial_rx #(
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sdi,
    input  logic            sfr,
    ex3_serial_rx_if.master e_if,
    output logic            ovr,
    output logic            busy
);
    localparam int DC_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [1:0]      bc;
    logic [DC_W-1:0] dc;
    logic [2:0]      hist;

    logic [3:0] digit_c;
    logic       done_c;
    logic       last_c;
    logic       take_c;
    logic       err_c;

    // The last three serial bits always sit in hist, so the nibble completing
    // on bc==3 is simply those bits followed by the current sdi.
    always_ff @(posedge clk) begin
        hist <= {hist[1:0], sdi};
    end

    assign digit_c = {hist, sdi};
    assign done_c  = (state == SHIFT) && !sfr && (bc == 2'd3);
    assign last_c  = (dc == DC_W'(DIGITS - 1));
    assign take_c  = done_c && (!e_if.e_valid || e_if.e_ready);

`ifdef EX3_CODE_CHECK_EN
    function automatic logic code_illegal(input logic [3:0] c);
        return (c < 4'd3) || (c > 4'd12);
    endfunction

    assign err_c = code_illegal(digit_c);
`else
    assign err_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bc           <= 2'd0;
            dc           <= '0;
            busy         <= 1'b0;
            ovr          <= 1'b0;
            e_if.E       <= 4'd0;
            e_if.e_valid <= 1'b0;
            e_if.e_last  <= 1'b0;
            e_if.e_err   <= 1'b0;
        end else begin
            ovr <= done_c && !take_c;

            if (take_c) begin
                e_if.E       <= digit_c;
                e_if.e_valid <= 1'b1;
                e_if.e_last  <= last_c;
                e_if.e_err   <= err_c;
            end else if (e_if.e_valid && e_if.e_ready) begin
                e_if.e_valid <= 1'b0;
            end

            // sfr wins in both states: a resync drops any partial or final digit.
            if (sfr) begin
                state <= SHIFT;
                busy  <= 1'b1;
                bc    <= 2'd1;
                dc    <= '0;
            end else if (state == SHIFT) begin
                bc <= bc + 2'd1;
                if (bc == 2'd3) begin
                    if (last_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        dc    <= '0;
                    end else begin
                        dc <= dc + DC_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ex3_serial_rx.sv
// Directed bench for ex3_serial_rx: framing, back-pressure/overrun, resync,
// code tagging, reset mid-operation and back-to-back frames.
module tb_ex3_serial_rx;
    logic clk;
    logic rst_n;
    logic sdi;
    logic sfr;
    logic ovr;
    logic busy;
    int   tests;
    int   failed;

`ifdef EX3_CODE_CHECK_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    ex3_serial_rx_if e_if ();

    ex3_serial_rx #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sdi   (sdi),
        .sfr   (sfr),
        .e_if  (e_if),
        .ovr   (ovr),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs read here belong to this cycle.
    task automatic tick(input logic s, input logic f, input logic r);
        @(negedge clk);
        sdi       = s;
        sfr       = f;
        e_if.e_ready = r;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [3:0] ee,
                           input logic el, input logic eo, input logic er);
        chk1({tag, ".valid"}, e_if.e_valid, ev);
        chk4({tag, ".E"}, e_if.E, ee);
        chk1({tag, ".last"}, e_if.e_last, el);
        chk1({tag, ".ovr"}, ovr, eo);
        chk1({tag, ".err"}, e_if.e_err, er);
    endtask

    // Shift one nibble MSB first; on its first cycle optionally check the
    // digit that completed at the end of the previous nibble.
    task automatic nib(input logic [3:0] n, input logic f, input logic r, input string tag,
                       input logic ev, input logic [3:0] ee, input logic el,
                       input logic eo, input logic er);
        for (int i = 0; i < 4; i++) begin
            tick(n[3-i], f && (i == 0), r);
            if (i == 0 && tag != "") chk_out(tag, ev, ee, el, eo, er);
        end
    endtask

    task automatic all_zero(input string tag);
        chk_out(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk1({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b1;
        sdi    = 1'b0;
        sfr    = 1'b0;
        e_if.e_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick(0, 0, 0);
        #1 all_zero("reset");
        tick(0, 0, 1);
        rst_n = 1'b1;
        tick(0, 0, 1);
        all_zero("idle");

        // Single frame, e_ready high: 3,7,12,8
        nib(4'd3,  1, 1, "",     0, 0,     0, 0, 0);
        chk1("t1.busy_mid", busy, 1'b1);
        nib(4'd7,  0, 1, "t1d0", 1, 4'd3,  0, 0, 0);
        nib(4'd12, 0, 1, "t1d1", 1, 4'd7,  0, 0, 0);
        nib(4'd8,  0, 1, "t1d2", 1, 4'd12, 0, 0, 0);
        chk1("t1.busy_t15", busy, 1'b1);
        tick(0, 0, 1);
        chk_out("t1d3", 1, 4'd8, 1, 0, 0);
        chk1("t1.busy_t16", busy, 1'b0);
        tick(0, 0, 1);
        chk1("t1.valid_t17", e_if.e_valid, 1'b0);

        // Back-pressure: e_ready low t+4..t+9, digit 1 overruns
        nib(4'd3, 1, 1, "",     0, 0,    0, 0, 0);
        nib(4'd7, 0, 0, "t2d0", 1, 4'd3, 0, 0, 0);
        tick(1, 0, 0);
        chk_out("t2t8", 1, 4'd3, 0, 1, 0);
        tick(1, 0, 0);
        chk_out("t2t9", 1, 4'd3, 0, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 1);
        chk1("t2.valid_t11", e_if.e_valid, 1'b0);
        nib(4'd8, 0, 1, "t2d2", 1, 4'd12, 0, 0, 0);
        tick(0, 0, 1);
        chk_out("t2d3", 1, 4'd8, 1, 0, 0);
        tick(0, 0, 1);

        // Resync at t+6 with new digit 0101
        nib(4'd3, 1, 1, "", 0, 0, 0, 0, 0);
        tick(0, 0, 1);
        chk_out("t3d0", 1, 4'd3, 0, 0, 0);
        tick(1, 0, 1);
        nib(4'd5, 1, 1, "", 0, 0, 0, 0, 0);
        chk1("t3.valid_t9", e_if.e_valid, 1'b0);
        chk1("t3.ovr_t9", ovr, 1'b0);
        chk1("t3.busy_t9", busy, 1'b1);
        nib(4'd9, 0, 1, "t3r0", 1, 4'd5, 0, 0, 0);
        nib(4'd4, 0, 1, "t3r1", 1, 4'd9, 0, 0, 0);
        nib(4'd6, 0, 1, "t3r2", 1, 4'd4, 0, 0, 0);
        tick(0, 0, 1);
        chk_out("t3r3", 1, 4'd6, 1, 0, 0);
        tick(0, 0, 1);

        // Code tagging: 0001 and 1110 illegal, 1001 and 0011 legal
        nib(4'd1,  1, 1, "",     0, 0,     0, 0, 0);
        nib(4'd14, 0, 1, "t4d0", 1, 4'd1,  0, 0, ERR);
        nib(4'd9,  0, 1, "t4d1", 1, 4'd14, 0, 0, ERR);
        nib(4'd3,  0, 1, "t4d2", 1, 4'd9,  0, 0, 0);
        tick(0, 0, 1);
        chk_out("t4d3", 1, 4'd3, 1, 0, 0);
        tick(0, 0, 1);

        // Reset at t+9 with digit 0 held and e_ready low
        nib(4'd3, 1, 1, "",     0, 0,    0, 0, 0);
        nib(4'd7, 0, 0, "t5d0", 1, 4'd3, 0, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk1("t5.held_t9", e_if.e_valid, 1'b1);
        rst_n = 1'b0;
        #1 all_zero("t5rst");
        tick(0, 0, 0);
        tick(0, 0, 0);
        all_zero("t5rst_hold");
        rst_n = 1'b1;
        tick(0, 0, 1);
        nib(4'd6, 1, 1, "",     0, 0,    0, 0, 0);
        nib(4'd7, 0, 1, "t5n0", 1, 4'd6, 0, 0, 0);
        nib(4'd8, 0, 1, "t5n1", 1, 4'd7, 0, 0, 0);
        nib(4'd9, 0, 1, "t5n2", 1, 4'd8, 0, 0, 0);
        tick(0, 0, 1);
        chk_out("t5n3", 1, 4'd9, 1, 0, 0);
        tick(0, 0, 1);

        // Back-to-back frames: 3,4,5,6 then 7,8,9,10 starting at t+16
        nib(4'd3,  1, 1, "",    0, 0,    0, 0, 0);
        nib(4'd4,  0, 1, "b0",  1, 4'd3, 0, 0, 0);
        nib(4'd5,  0, 1, "b1",  1, 4'd4, 0, 0, 0);
        nib(4'd6,  0, 1, "b2",  1, 4'd5, 0, 0, 0);
        nib(4'd7,  1, 1, "b3",  1, 4'd6, 1, 0, 0);
        chk1("b.busy_t19", busy, 1'b1);
        nib(4'd8,  0, 1, "b4",  1, 4'd7, 0, 0, 0);
        nib(4'd9,  0, 1, "b5",  1, 4'd8, 0, 0, 0);
        nib(4'd10, 0, 1, "b6",  1, 4'd9, 0, 0, 0);
        tick(0, 0, 1);
        chk_out("b7", 1, 4'd10, 1, 0, 0);
        chk1("b.busy_end", busy, 1'b0);
        tick(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
